// File: rtl/param_pipe_reg.sv
// param_pipe_reg: moves a WIDTH-bit word and its valid flag through DEPTH
// clocked stages. Supports a clock-enable stall, a synchronous flush back to
// INIT, and an in-flight occupancy count with empty/full flags.
// All outputs come straight from flops or from simple decodes of flops, so no
// input reaches an output without passing through a register.

module param_pipe_reg #(
    parameter int             WIDTH = 8,
    parameter int             DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
    localparam int            CW    = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    // Occupancy counter state and its next value.
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          last_valid_s;

    // One generate iteration per stage. Stage 0 is fed from the input port;
    // every later stage is fed from the stage before it.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_r;
        logic [WIDTH-1:0] d_in_s;
        logic [WIDTH-1:0] d_nxt_s;
        logic             v_r;
        logic             v_in_s;
        logic             v_nxt_s;

        if (k == 0) begin : g_first
            assign d_in_s = i;
            assign v_in_s = i_valid;
        end else begin : g_chain
            assign d_in_s = g_stage[k-1].d_r;
            assign v_in_s = g_stage[k-1].v_r;
        end

        // Stage next-state: flush beats shift, shift beats hold.
        always_comb begin
            d_nxt_s = d_r;
            v_nxt_s = v_r;
            if (flush) begin
                d_nxt_s = INIT;
                v_nxt_s = 1'b0;
            end else if (ce) begin
                d_nxt_s = d_in_s;
                v_nxt_s = v_in_s;
            end else begin
                d_nxt_s = d_r;
                v_nxt_s = v_r;
            end
        end

        // Stage register; reset loads INIT so nothing starts as X.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_r <= INIT;
                v_r <= 1'b0;
            end else begin
                d_r <= d_nxt_s;
                v_r <= v_nxt_s;
            end
        end
    end

    assign last_valid_s = g_stage[DEPTH-1].v_r;

    // Counter next-state. On a shift the count gains the incoming valid and
    // loses the valid leaving the last stage; the true result always lies in
    // 0..DEPTH, so modular CW-bit arithmetic gives the exact value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (flush) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (ce) begin
            cnt_nxt_s = cnt_r + CW'(i_valid) - CW'(last_valid_s);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign o       = g_stage[DEPTH-1].d_r;
    assign o_valid = last_valid_s;
    assign count   = cnt_r;
    assign empty   = (cnt_r == {CW{1'b0}});
    assign full    = (cnt_r == CW'(DEPTH));

endmodule

// File: tb/tb_param_pipe_reg.sv
// Testbench for param_pipe_reg: a DEPTH=3/INIT=0 instance carries most of
// the scenarios, and a DEPTH=1/INIT=5A instance covers the single-flop case.
// A scoreboard queue records every valid word at the edge that samples it,
// together with the ce-edge index on which it must reach the output.

module tb_param_pipe_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic [7:0] i;
    logic       i_valid;

    logic [7:0] o3;
    logic       ov3;
    logic [1:0] cnt3;
    logic       em3;
    logic       fu3;

    logic [7:0] o1;
    logic       ov1;
    logic [0:0] cnt1;
    logic       em1;
    logic       fu1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   ce_idx = 0;

    always #5 clk = ~clk;

    param_pipe_reg #(.WIDTH(8), .DEPTH(3), .INIT(8'h00)) u3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .i(i), .i_valid(i_valid),
        .o(o3), .o_valid(ov3), .count(cnt3), .empty(em3), .full(fu3)
    );

    param_pipe_reg #(.WIDTH(8), .DEPTH(1), .INIT(8'h5A)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .i(i), .i_valid(i_valid),
        .o(o1), .o_valid(ov1), .count(cnt1), .empty(em1), .full(fu1)
    );

    // Scoreboard for the DEPTH=3 instance: push on sampling edge, pop on due edge.
    always @(posedge clk) begin : scoreboard
        logic       e_ce, e_fl, e_rst, e_iv;
        logic [7:0] e_d;
        int         this_idx;
        exp_t       it;
        e_rst = rst_n; e_ce = ce; e_fl = flush; e_iv = i_valid; e_d = i;
        if (!e_rst || e_fl) begin
            exp_q.delete();
        end else if (e_ce) begin
            this_idx = ce_idx;
            ce_idx++;
            if (e_iv) begin
                it.d = e_d; it.due = this_idx + 2;
                exp_q.push_back(it);
            end
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == this_idx) begin
                it = exp_q.pop_front();
                total_cnt++;
                if (ov3 !== 1'b1 || o3 !== it.d)
                    $display("FAIL sb_out: o=%0h o_valid=%0b, expected o=%0h o_valid=1", o3, ov3, it.d);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (ov3 !== 1'b0) $display("FAIL sb_idle: o_valid=%0b o=%0h, expected o_valid=0", ov3, o3);
                else pass_cnt++;
            end
        end
    end

    task automatic drive(input logic c, input logic f, input logic [7:0] d, input logic v);
        ce = c; flush = f; i = d; i_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (o3 !== 8'h00) $display("FAIL rst_o: got %0h want 00", o3); else pass_cnt++;
        total_cnt++; if (ov3 !== 1'b0) $display("FAIL rst_ov: got %0b want 0", ov3); else pass_cnt++;
        total_cnt++; if (cnt3 !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", cnt3); else pass_cnt++;
        total_cnt++; if (em3 !== 1'b1) $display("FAIL rst_empty: got %0b want 1", em3); else pass_cnt++;
        total_cnt++; if (fu3 !== 1'b0) $display("FAIL rst_full: got %0b want 0", fu3); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (o3 !== 8'h00 || ov3 !== 1'b0 || cnt3 !== 2'd0)
            $display("FAIL rst_hold: got o=%0h ov=%0b cnt=%0d want 00/0/0", o3, ov3, cnt3); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [1:0] exp_cnt [4];
        logic       exp_ov  [4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd1; exp_cnt[2] = 2'd1; exp_cnt[3] = 2'd0;
        exp_ov[0] = 1'b0;  exp_ov[1] = 1'b0;  exp_ov[2] = 1'b1;  exp_ov[3] = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (e == 0) drive(1'b1, 1'b0, 8'hA5, 1'b1);
            else        drive(1'b1, 1'b0, 8'h00, 1'b0);
            total_cnt++; if (cnt3 !== exp_cnt[e]) $display("FAIL lat_cnt%0d: got %0d want %0d", e, cnt3, exp_cnt[e]); else pass_cnt++;
            total_cnt++; if (ov3 !== exp_ov[e]) $display("FAIL lat_ov%0d: got %0b want %0b", e, ov3, exp_ov[e]); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 8'h11, 1'b1);
        drive(1'b1, 1'b0, 8'h22, 1'b1);
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b0, 8'h77, 1'b1);
            total_cnt++; if (cnt3 !== 2'd2 || o3 !== 8'h00 || ov3 !== 1'b0)
                $display("FAIL stall_hold%0d: got cnt=%0d o=%0h ov=%0b want 2/00/0", s, cnt3, o3, ov3); else pass_cnt++;
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        total_cnt++; if (o3 !== 8'h11 || ov3 !== 1'b1 || cnt3 !== 2'd2)
            $display("FAIL stall_r1: got o=%0h ov=%0b cnt=%0d want 11/1/2", o3, ov3, cnt3); else pass_cnt++;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        total_cnt++; if (o3 !== 8'h22 || ov3 !== 1'b1 || cnt3 !== 2'd1)
            $display("FAIL stall_r2: got o=%0h ov=%0b cnt=%0d want 22/1/1", o3, ov3, cnt3); else pass_cnt++;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        total_cnt++; if (ov3 !== 1'b0 || cnt3 !== 2'd0 || em3 !== 1'b1)
            $display("FAIL stall_r3: got ov=%0b cnt=%0d empty=%0b want 0/0/1", ov3, cnt3, em3); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [1:0] ec;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 8'(k), 1'b1);
            ec = (k < 3) ? 2'(k) : 2'd3;
            total_cnt++; if (cnt3 !== ec) $display("FAIL full_cnt%0d: got %0d want %0d", k, cnt3, ec); else pass_cnt++;
            total_cnt++; if (fu3 !== (k >= 3)) $display("FAIL full_flag%0d: got %0b want %0b", k, fu3, (k >= 3)); else pass_cnt++;
            if (k >= 3) begin
                total_cnt++; if (o3 !== 8'(k - 2)) $display("FAIL full_o%0d: got %0h want %0h", k, o3, 8'(k - 2)); else pass_cnt++;
            end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        total_cnt++; if (o3 !== 8'h00 || ov3 !== 1'b0) $display("FAIL flush_o: got o=%0h ov=%0b want 00/0", o3, ov3); else pass_cnt++;
        total_cnt++; if (cnt3 !== 2'd0 || em3 !== 1'b1 || fu3 !== 1'b0)
            $display("FAIL flush_cnt: got cnt=%0d empty=%0b full=%0b want 0/1/0", cnt3, em3, fu3); else pass_cnt++;
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            total_cnt++; if (o3 === 8'hFF || ov3 !== 1'b0) $display("FAIL flush_leak%0d: got o=%0h ov=%0b want not FF/0", s, o3, ov3); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 8'hA1, 1'b1);
        drive(1'b1, 1'b0, 8'hA2, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        total_cnt++; if (cnt3 !== 2'd2 || o3 !== 8'hA1) $display("FAIL ar_pre: got cnt=%0d o=%0h want 2/A1", cnt3, o3); else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (o3 !== 8'h00 || ov3 !== 1'b0) $display("FAIL ar_o: got o=%0h ov=%0b want 00/0", o3, ov3); else pass_cnt++;
        total_cnt++; if (cnt3 !== 2'd0 || em3 !== 1'b1) $display("FAIL ar_cnt: got cnt=%0d empty=%0b want 0/1", cnt3, em3); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            drive(($urandom_range(0, 3) != 0), 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d words outstanding, want 0", exp_q.size()); else pass_cnt++;
        total_cnt++; if (cnt3 !== 2'd0) $display("FAIL b2b_cnt: got %0d want 0", cnt3); else pass_cnt++;
    endtask

    task automatic test_depth1();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (o1 !== 8'h5A || ov1 !== 1'b0) $display("FAIL d1_rst_o: got o=%0h ov=%0b want 5A/0", o1, ov1); else pass_cnt++;
        total_cnt++; if (cnt1 !== 1'b0 || em1 !== 1'b1 || fu1 !== 1'b0)
            $display("FAIL d1_rst_cnt: got cnt=%0d empty=%0b full=%0b want 0/1/0", cnt1, em1, fu1); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h3C, 1'b1);
        total_cnt++; if (o1 !== 8'h3C || ov1 !== 1'b1) $display("FAIL d1_o: got o=%0h ov=%0b want 3C/1", o1, ov1); else pass_cnt++;
        total_cnt++; if (fu1 !== 1'b1 || cnt1 !== 1'b1) $display("FAIL d1_full: got full=%0b cnt=%0d want 1/1", fu1, cnt1); else pass_cnt++;
        drive(1'b1, 1'b0, 8'hC3, 1'b0);
        total_cnt++; if (o1 !== 8'hC3 || ov1 !== 1'b0 || fu1 !== 1'b0 || em1 !== 1'b1)
            $display("FAIL d1_inv: got o=%0h ov=%0b full=%0b empty=%0b want C3/0/0/1", o1, ov1, fu1, em1); else pass_cnt++;
        drive(1'b0, 1'b0, 8'h11, 1'b1);
        total_cnt++; if (o1 !== 8'hC3 || cnt1 !== 1'b0) $display("FAIL d1_hold: got o=%0h cnt=%0d want C3/0", o1, cnt1); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b1; ce = 1'b0; flush = 1'b0; i = 8'h00; i_valid = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_stall();
        test_full();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_depth1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/param_pipe_reg.md
Name: param_pipe_reg

Overview:
- Parametrised successor to the single-flop registered-output test design.
- Moves a WIDTH-bit data word and its valid flag through DEPTH clocked stages.
- Adds clock-enable stall, synchronous flush, a configurable init value and an in-flight occupancy count.
- Used as a top-level test design for clock-constraint propagation through multi-stage register chains, and as a generic retiming and delay primitive.

Parameters:
- WIDTH, 8, data width in bits; legal range 1 and up.
- DEPTH, 3, number of register stages; legal range 1 and up. DEPTH=1 gives a single-flop registered output.
- INIT, 0, WIDTH-bit value loaded into every data stage on reset and on flush.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; 1 = shift, 0 = hold.
- flush  input  1  synchronous clear of the pipeline contents.
- i  input  WIDTH  data in.
- i_valid  input  1  marks i as valid.
- o  output  WIDTH  data out; equals the last stage.
- o_valid  output  1  valid flag of the last stage.
- count  output  CW  number of valid entries in flight, where CW = $clog2(DEPTH+1), minimum 1.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.

Behaviour:
- State:
  - Data stages d[0..DEPTH-1], each WIDTH bits.
  - Valid flags v[0..DEPTH-1].
  - Occupancy counter cnt, CW bits.
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - All d[k] = INIT, all v[k] = 0, cnt = 0.
  - Outputs during and after reset: o=INIT, o_valid=0, count=0, empty=1, full=0.
- Reset release: synchronous to clk. The first edge with rst_n=1 performs a normal update.
- Priority per rising edge is flush > ce > hold.
- flush=1 (ce ignored):
  - All d[k] <= INIT, all v[k] <= 0, cnt <= 0.
  - i and i_valid on this edge are discarded.
- flush=0, ce=1 (shift):
  - d[0] <= i, v[0] <= i_valid.
  - d[k] <= d[k-1] and v[k] <= v[k-1] for k=1..DEPTH-1.
  - cnt <= cnt + i_valid - v[DEPTH-1], computed at CW+1 bits then truncated.
  - The result is always within 0..DEPTH. When i_valid=1 and v[DEPTH-1]=1, cnt is unchanged.
- flush=0, ce=0 (hold):
  - All state holds. i and i_valid are ignored.
  - The data word is not lost; it is simply not sampled.
- Latency: a word sampled on ce edge N appears on o, with o_valid=1, after ce edge N+DEPTH-1 has completed.
  - In other words, DEPTH ce-qualified edges from input sample to output.
  - Stalled cycles (ce=0) do not count.
- Invalid words (i_valid=0):
  - Data still shifts.
  - o shows whatever data occupies the last stage; consumers must qualify with o_valid.
- Outputs:
  - o, o_valid, count, empty and full are driven directly or combinationally from registers.
  - No combinational path from any input to any output.
- DEPTH=1:
  - o <= i on each ce edge.
  - cnt toggles between 0 and 1.
  - full = o_valid.
- Boundary conditions:
  - Pipeline full with ce=1 and i_valid=1: cnt stays DEPTH. There is no overflow and no backpressure; the block never refuses input.
  - Flush while full: cnt goes to 0 in one edge.
  - Reset mid-stream: all in-flight data lost; behaviour as reset.
- No X propagation from the initial state: every flop has a defined reset value.

Test Plan:
- Reset and latency:
  - Stimulus: WIDTH=8, DEPTH=3, INIT=8'h00. Hold rst_n=0 for 2 cycles, release, ce=1, then drive i=8'hA5 with i_valid=1 for 1 cycle.
  - Required: o=8'hA5 and o_valid=1 exactly after the 3rd edge; o_valid=0 on the edges before and after; count sequence 1,1,1,0.
- Stall:
  - Stimulus: same setup, send 8'h11 then 8'h22 back to back, then ce=0 for 4 cycles, then ce=1.
  - Required: o and count frozen during the stall; 8'h11 emerges on the 1st ce edge after resume, 8'h22 on the 2nd.
- Full and steady state:
  - Stimulus: i_valid=1 continuously with i incrementing from 1.
  - Required: count reaches 3 after 3 edges, full=1, count stays 3 while o tracks i delayed by 3 (o=1 when i=4).
- Flush priority:
  - Stimulus: full pipeline, assert flush=1 with ce=1 and i=8'hFF, i_valid=1.
  - Required: next edge gives o=INIT, o_valid=0, count=0, empty=1; 8'hFF never appears at o.
- Async reset mid-stream:
  - Stimulus: pull rst_n low between clock edges while count=2.
  - Required: o=INIT, o_valid=0, count=0 before the next clk edge.
- DEPTH=1 with INIT=8'h5A:
  - Required: after reset o=8'h5A; with ce=1, i=8'h3C, i_valid=1 gives o=8'h3C and full=1 after 1 edge.
